// File: rtl/rst_sequencer_pkg.sv
// Shared constants for the staged reset sequencer: bus widths, register offsets,
// access-size codes and FSM state encodings (also reported in STAT[14:12]).
package rst_sequencer_pkg;
  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;
  localparam int RST_SEQ_SIZE  = 16;

  // acc code 0 is a byte access; no register accepts it
  localparam logic [BUS_ACC_WIDTH-1:0] ACC_2B = 2'd1;
  localparam logic [BUS_ACC_WIDTH-1:0] ACC_4B = 2'd2;

  localparam logic [3:0] ADDR_HOLD  = 4'h0;
  localparam logic [3:0] ADDR_SWRST = 4'h2;
  localparam logic [3:0] ADDR_DLY   = 4'h4;
  localparam logic [3:0] ADDR_STAT  = 4'h8;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_DONE  = 3'd2,
    S_SWRST = 3'd3
  } state_e;
endpackage

// File: rtl/rst_sequencer_if.sv
// Register-bus handshake between a bus master and the reset sequencer slave.
interface rst_sequencer_if import rst_sequencer_pkg::*; ();
  logic [3:0]               addr;
  logic                     w_rb;
  logic [BUS_ACC_WIDTH-1:0] acc;
  logic [BUS_WIDTH-1:0]     wdata;
  logic [BUS_WIDTH-1:0]     rdata;
  logic                     req;
  logic                     resp;
  logic                     fault;

  modport master (output addr, w_rb, acc, wdata, req, input rdata, resp, fault);
  modport slave  (input addr, w_rb, acc, wdata, req, output rdata, resp, fault);
endinterface

// File: rtl/rst_sequencer_rst_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts after STAGES clock edges.
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_ib,
  output logic rst_ob
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_ib) begin
    if (!rst_ib) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], 1'b1};
  end

  assign rst_ob = sync_q[STAGES-1];
endmodule

// File: rtl/rst_sequencer.sv
// Staged reset-release sequencer with HOLD/SWRST/DLY/STAT registers.
// Define RST_SEQ_ACK_EN to add dom_rdy handshaking between stages and after SWRST.
module rst_sequencer import rst_sequencer_pkg::*; #(
  parameter int N_DOM       = 4,
  parameter int DLY_RST     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_ib,
`ifdef RST_SEQ_ACK_EN
  input  logic [N_DOM-1:0] dom_rdy,
`endif
  output logic [N_DOM-1:0] rst_dom_ob,
  output logic             seq_done,
  rst_sequencer_if.slave   bus
);
  localparam logic [N_DOM-1:0] DOM0     = N_DOM'(1);
  localparam logic [4:0]       LAST_STG = 5'(N_DOM - 1);

  logic                    rst_s;
  state_e                  state_q;
  logic [RST_SEQ_SIZE-1:0] cnt_q, dly_q;
  logic [4:0]              stg_q;
  logic [N_DOM-1:0]        rst_dom_q, hold_q, swm_q, wait_q;
  logic [N_DOM-1:0]        stg_oh, rdy_w, swrst_m;
  logic                    seq_done_q, resp_q, bad, acc_ok, swrst_wr;
  logic [BUS_WIDTH-1:0]    rdata_q, rd_d;
  logic [15:0]             stat_w;
  logic                    unused_wdata;

`ifdef RST_SEQ_ACK_EN
  localparam bit ACK_EN = 1'b1;
  assign rdy_w = dom_rdy;
`else
  localparam bit ACK_EN = 1'b0;
  assign rdy_w = '1;
`endif

  rst_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_ib(rst_ib), .rst_ob(rst_s));

  always_comb begin
    bad = 1'b0;
    case (bus.addr)
      ADDR_HOLD:  bad = (bus.acc != ACC_2B);
      ADDR_SWRST: bad = (bus.acc != ACC_2B) || !bus.w_rb;
      ADDR_DLY:   bad = (bus.acc != ACC_4B);
      ADDR_STAT:  bad = (bus.acc != ACC_2B) || bus.w_rb;
      default:    bad = 1'b1;
    endcase
  end

  assign bus.fault = bus.req & bad;
  assign acc_ok    = bus.req & ~bad;
  assign swrst_wr  = acc_ok & bus.w_rb & (bus.addr == ADDR_SWRST);
  assign swrst_m   = bus.wdata[N_DOM-1:0] & ~DOM0;
  assign stg_oh    = DOM0 << stg_q;
  assign stat_w    = {seq_done_q, state_q, |wait_q, 7'b0, stg_q[3:0]};

  always_comb begin
    rd_d = '0;
    case (bus.addr)
      ADDR_HOLD: rd_d[N_DOM-1:0]        = hold_q;
      ADDR_DLY:  rd_d[RST_SEQ_SIZE-1:0] = dly_q;
      ADDR_STAT: rd_d[15:0]             = stat_w;
      default:   rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      hold_q  <= '0;
      dly_q   <= RST_SEQ_SIZE'(DLY_RST);
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q <= acc_ok;
      if (acc_ok && bus.w_rb && bus.addr == ADDR_HOLD) hold_q <= bus.wdata[N_DOM-1:0] & ~DOM0;
      if (acc_ok && bus.w_rb && bus.addr == ADDR_DLY)  dly_q  <= bus.wdata[RST_SEQ_SIZE-1:0];
      if (acc_ok && !bus.w_rb)                         rdata_q <= rd_d;
    end
  end

  // wait_q holds the domains whose ready is still outstanding; always zero without ACK_EN
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      state_q    <= S_RESET;
      cnt_q      <= '0;
      stg_q      <= '0;
      rst_dom_q  <= '0;
      seq_done_q <= 1'b0;
      swm_q      <= '0;
      wait_q     <= '0;
    end else begin
      case (state_q)
        S_RESET: begin
          state_q <= S_WAIT;
          cnt_q   <= dly_q;
          stg_q   <= '0;
        end
        S_WAIT: begin
          if (wait_q != '0) begin
            if ((wait_q & ~rdy_w) == '0) wait_q <= '0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rst_dom_q <= rst_dom_q | (stg_oh & ~hold_q);
            stg_q     <= stg_q + 1'b1;
            cnt_q     <= dly_q;
            if (stg_q == LAST_STG) begin
              state_q    <= S_DONE;
              seq_done_q <= 1'b1;
            end else if (ACK_EN) begin
              wait_q <= stg_oh & ~hold_q;
            end
          end
        end
        S_DONE: begin
          rst_dom_q <= ~hold_q;
          if (swrst_wr && swrst_m != '0) begin
            state_q    <= S_SWRST;
            swm_q      <= swrst_m;
            cnt_q      <= dly_q;
            seq_done_q <= 1'b0;
            rst_dom_q  <= ~hold_q & ~swrst_m;
          end
        end
        S_SWRST: begin
          rst_dom_q <= ~hold_q & ~swm_q;
          if (wait_q != '0) begin
            rst_dom_q <= ~hold_q;
            if ((wait_q & ~rdy_w) == '0) begin
              wait_q     <= '0;
              state_q    <= S_DONE;
              seq_done_q <= 1'b1;
            end
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rst_dom_q <= ~hold_q;
            if (ACK_EN && ((swm_q & ~hold_q) != '0)) begin
              wait_q <= swm_q & ~hold_q;
            end else begin
              state_q    <= S_DONE;
              seq_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_RESET;
      endcase
    end
  end

  assign rst_dom_ob   = rst_dom_q;
  assign seq_done     = seq_done_q;
  assign bus.resp     = resp_q;
  assign bus.rdata    = rdata_q;
  assign unused_wdata = ^bus.wdata[BUS_WIDTH-1:RST_SEQ_SIZE];
endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer in its default build (N_DOM=4, DLY_RST=16).
module tb_rst_sequencer;
  logic       clk = 1'b0;
  logic       rst_ib = 1'b0;
  logic [3:0] rst_dom_ob;
  logic       seq_done;
  int         n_checks = 0;
  int         n_errors = 0;
  int         ecount = 0;
  int         e_sw;
  logic [31:0] rd;

  rst_sequencer_if bus();

  rst_sequencer #(.N_DOM(4), .DLY_RST(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_ib(rst_ib), .rst_dom_ob(rst_dom_ob), .seq_done(seq_done), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ecount++;
    end
  endtask

  task automatic go_to(input int e);
    while (ecount < e) step(1);
  endtask

  // Holds rst_ib low, then releases it between edges; ecount restarts at 0 so T0 is edge 3.
  task automatic do_reset();
    rst_ib = 1'b0;
    step(3);
    rst_ib = 1'b1;
    ecount = 0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [1:0] sz, input logic [31:0] d, input string tag);
    bus.addr = a; bus.acc = sz; bus.w_rb = 1'b1; bus.wdata = d; bus.req = 1'b1;
    #1 check({tag, " fault"}, {31'b0, bus.fault}, 32'd0);
    @(posedge clk); #1; ecount++;
    bus.req = 1'b0;
    check({tag, " resp"}, {31'b0, bus.resp}, 32'd1);
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [1:0] sz, output logic [31:0] d, input string tag);
    bus.addr = a; bus.acc = sz; bus.w_rb = 1'b0; bus.req = 1'b1;
    #1 check({tag, " fault"}, {31'b0, bus.fault}, 32'd0);
    @(posedge clk); #1; ecount++;
    bus.req = 1'b0;
    check({tag, " resp"}, {31'b0, bus.resp}, 32'd1);
    d = bus.rdata;
  endtask

  task automatic bus_fault(input logic [3:0] a, input logic w, input logic [1:0] sz, input string tag);
    bus.addr = a; bus.acc = sz; bus.w_rb = w; bus.wdata = 32'h0000_000E; bus.req = 1'b1;
    #1 check({tag, " fault"}, {31'b0, bus.fault}, 32'd1);
    @(posedge clk); #1; ecount++;
    bus.req = 1'b0;
    check({tag, " no resp"}, {31'b0, bus.resp}, 32'd0);
    step(1);
    check({tag, " no late resp"}, {31'b0, bus.resp}, 32'd0);
  endtask

  task automatic seq_default(input string tag);
    go_to(19); check({tag, " e19"}, {28'b0, rst_dom_ob}, 32'h0);
    go_to(20); check({tag, " e20 dom0"}, {28'b0, rst_dom_ob}, 32'h1);
    go_to(36); check({tag, " e36"}, {28'b0, rst_dom_ob}, 32'h1);
    go_to(37); check({tag, " e37 dom1"}, {28'b0, rst_dom_ob}, 32'h3);
    go_to(54); check({tag, " e54 dom2"}, {28'b0, rst_dom_ob}, 32'h7);
    go_to(70); check({tag, " e70"}, {27'b0, seq_done, rst_dom_ob}, 32'h07);
    go_to(71); check({tag, " e71 done"}, {27'b0, seq_done, rst_dom_ob}, 32'h1F);
  endtask

  initial begin
    bus.addr = '0; bus.acc = '0; bus.w_rb = 1'b0; bus.wdata = '0; bus.req = 1'b0;

    // reset state and default sequence
    step(3);
    check("reset rst_dom", {28'b0, rst_dom_ob}, 32'h0);
    check("reset seq_done", {31'b0, seq_done}, 32'h0);
    check("reset resp", {31'b0, bus.resp}, 32'h0);
    check("reset rdata", bus.rdata, 32'h0);
    rst_ib = 1'b1;
    ecount = 0;
    seq_default("seq1");
    bus_read(4'h4, 2'd2, rd, "rd dly default"); check("dly default", rd, 32'd16);

    // DLY upper half ignored; DLY restored to 16 by reset
    bus_write(4'h4, 2'd2, 32'hABCD_0000, "wr dly0");
    bus_read(4'h4, 2'd2, rd, "rd dly0"); check("dly upper ignored", rd, 32'h0);
    do_reset();
    seq_default("seq2");

    // DLY=3 before stage-1 reload; SWRST outside S_DONE ignored
    do_reset();
    go_to(4); bus_write(4'h2, 2'd1, 32'h0000_000E, "swrst in wait");
    go_to(9); bus_write(4'h4, 2'd2, 32'd3, "wr dly3");
    go_to(19); check("dly3 e19", {28'b0, rst_dom_ob}, 32'h0);
    go_to(20); check("dly3 e20", {28'b0, rst_dom_ob}, 32'h1);
    go_to(23); check("dly3 e23", {28'b0, rst_dom_ob}, 32'h1);
    go_to(24); check("dly3 e24", {28'b0, rst_dom_ob}, 32'h3);
    go_to(28); check("dly3 e28", {28'b0, rst_dom_ob}, 32'h7);
    go_to(31); check("dly3 e31", {27'b0, seq_done, rst_dom_ob}, 32'h07);
    go_to(32); check("dly3 e32", {27'b0, seq_done, rst_dom_ob}, 32'h1F);

    // HOLD dom2 (bit0 written but ignored), then release in S_DONE
    do_reset();
    go_to(39); bus_write(4'h0, 2'd1, 32'h0000_0005, "wr hold");
    bus_read(4'h0, 2'd1, rd, "rd hold"); check("hold bit0 ignored", rd, 32'h4);
    go_to(54); check("hold e54", {28'b0, rst_dom_ob}, 32'h3);
    go_to(71); check("hold e71", {27'b0, seq_done, rst_dom_ob}, 32'h1B);
    bus_write(4'h0, 2'd1, 32'h0, "clr hold");
    check("hold clr same edge", {28'b0, rst_dom_ob}, 32'hB);
    step(1); check("hold clr next edge", {28'b0, rst_dom_ob}, 32'hF);

    // soft reset of dom1/dom3 with DLY=5
    bus_write(4'h4, 2'd2, 32'd5, "wr dly5");
    bus_write(4'h2, 2'd1, 32'h0000_000A, "wr swrst");
    e_sw = ecount;
    check("swrst start", {27'b0, seq_done, rst_dom_ob}, 32'h05);
    go_to(e_sw + 5); check("swrst +5", {27'b0, seq_done, rst_dom_ob}, 32'h05);
    go_to(e_sw + 6); check("swrst +6", {27'b0, seq_done, rst_dom_ob}, 32'h1F);
    bus_read(4'h8, 2'd1, rd, "rd stat"); check("stat done", rd, 32'h0000_A004);
    bus_write(4'h2, 2'd1, 32'h0000_0001, "swrst m0");
    step(1); check("swrst m0 no effect", {27'b0, seq_done, rst_dom_ob}, 32'h1F);

    // faulted accesses
    bus_fault(4'h2, 1'b0, 2'd1, "rd swrst");
    bus_fault(4'h8, 1'b1, 2'd1, "wr stat");
    bus_fault(4'h0, 1'b1, 2'd2, "4B hold");
    bus_fault(4'h6, 1'b0, 2'd1, "addr6");
    bus_fault(4'h2, 1'b1, 2'd2, "4B swrst");
    check("fault no state change", {27'b0, seq_done, rst_dom_ob}, 32'h1F);
    bus_read(4'h0, 2'd1, rd, "rd hold after fault"); check("hold unchanged", rd, 32'h0);
    bus_read(4'h4, 2'd2, rd, "rd dly after fault"); check("dly unchanged", rd, 32'd5);

    // asynchronous abort at T0+40, then a clean restart
    do_reset();
    go_to(43); check("abort before", {28'b0, rst_dom_ob}, 32'h3);
    rst_ib = 1'b0;
    #1 check("abort async", {27'b0, seq_done, rst_dom_ob}, 32'h0);
    do_reset();
    seq_default("seq3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
Staged reset-release sequencer placed directly downstream of the global reset controller's active-low reset output. It fans one reset into N_DOM per-domain active-low resets and releases them in fixed order (domain 0 first) with a programmable gap between stages. It also exposes a small bus-slave register file for software hold masks, per-domain soft reset and status.

Parameters:
N_DOM, 4, number of reset domains (2..16); domain 0 is the bus master's domain.
DLY_RST, 16, reset value of DLY register (gap cycles minus 1).
SYNC_STAGES, 2, deassertion synchronizer depth (>=2).

Ports:
clk  in  1  system clock
rst_ib  in  1  asynchronous active-low reset (from global reset controller output)
rst_dom_ob  out  N_DOM  per-domain resets, active low
seq_done  out  1  high once all stages are processed and no soft reset is in progress
addr  in  4  register byte address
w_rb  in  1  1=write, 0=read
acc  in  `BUS_ACC_WIDTH  access size
rdata  out  `BUS_WIDTH  read data
wdata  in  `BUS_WIDTH  write data
req  in  1  access request
resp  out  1  access response
fault  out  1  access fault
dom_rdy  in  N_DOM  per-domain ready (only with RST_SEQ_ACK_EN)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_ib). While rst_ib=0: rst_dom_ob=0, seq_done=0, resp=0, rdata=0, state S_RESET, HOLD=0, DLY=DLY_RST, stg=0, cnt=0. Assertion mid-sequence or mid-soft-reset aborts immediately.
- Deassertion passes through the rst_sync sub-module; T0 = first edge where synced reset is high. At T0: state S_WAIT, cnt=DLY[15:0], stg=0.
- S_WAIT: cnt decrements each cycle. When cnt==0, release domain stg next edge (rst_dom_ob[stg]=1 unless HOLD[stg]), stg+1, cnt reloads DLY. Release k+1 occurs DLY+1 cycles after release k. Domain 0 is released at T0+DLY+1.
- After stg N_DOM-1 is released: S_DONE, seq_done=1. DLY=0 releases one domain per cycle.
- HOLD (bit0 ignored, reads 0): a held stage still consumes its slot. In S_DONE, clearing bit i releases domain i next edge; setting bit i asserts it next edge.
- SWRST write in S_DONE with mask m (bit0 ignored, m!=0): next edge, domains in m asserted, seq_done=0, state S_SWRST, cnt=DLY. When cnt==0, all of m not held are released together; return to S_DONE. SWRST writes outside S_DONE, or with m==0, get a normal resp and no effect.
- DLY written mid-sequence takes effect at the next reload.
- Register map (addr, size, access):
  - 0 HOLD 2B RW
  - 2 SWRST 2B W
  - 4 DLY 4B RW: [15:0] used, [31:16] write-ignored, read 0
  - 8 STAT 2B R: [15]=seq_done, [14:12]=state, [3:0]=stg
- fault = req & invalid, combinational. Invalid means: address not in {0,2,4,8}; acc not 4B at addr 4 or not 2B elsewhere; write to STAT; read of SWRST.
- resp is registered: resp = 1 exactly one cycle after a valid req; no resp for faulted req. rdata updates only on a valid read and holds otherwise. Writes take effect at the edge where req is sampled.

Optional Feature:
- RST_SEQ_ACK_EN defined: port dom_rdy is present. After releasing stage k, the counter for stage k+1 starts only once dom_rdy[k]=1 (held stages skip the wait). SWRST completion waits for dom_rdy of all released domains before seq_done=1. STAT[11]=waiting-for-ready.
- Undefined: port is absent, behaviour is as above, and STAT[11] reads 0.

Decomposition:
- femto.vh additions: `RST_SEQ_SIZE (16), register offsets, state encodings (S_RESET, S_WAIT, S_DONE, S_SWRST).
- Sub-module rst_sync: async-assert, sync-deassert, SYNC_STAGES flops.

Test Plan:
- rst_ib rises, defaults (DLY=16, N_DOM=4) -> rst_dom_ob goes 0001 at T0+17, 0011 at T0+34, 0111 at T0+51, 1111 at T0+68; seq_done=1 at T0+68.
- Write DLY=0 then assert/deassert rst_ib -> DLY resets to 16 and the sequence of test 1 repeats. Write DLY=3 during S_WAIT before stage 1 reload -> subsequent gaps are 4 cycles.
- HOLD=0x0004 written before stage 2 -> dom2 stays 0 and seq_done=1 at T0+68; then write HOLD=0 -> rst_dom_ob=1111 next edge.
- In S_DONE, SWRST=0x000A with DLY=5 -> dom1 and dom3 are 0 for 6 cycles, then 1; seq_done low during that window; STAT read returns [15]=1 afterwards.
- Faults: read addr 2, write addr 8, 4B access at addr 0, addr 6 -> fault=1 same cycle, resp never asserted, no state change.
- rst_ib pulled low at T0+40 -> all outputs 0 asynchronously; after release the sequence restarts from domain 0.
